bp_fe_fetch_buffer: RTL
=======================

# bp_fe_fetch_buffer

Decoupling buffer between the front-end PC generator's IF2 output and the front-end queue. It captures each fetched PC, instruction, branch metadata and fetch-exception code into an `els_p`-deep circular FIFO and presents them in order to the FE-queue packer. It is flushed on redirect. After accepting a fetch exception, it refuses further fetches until the next flush, so the backend sees at most one exception per fetch stream.

## Interface
- `vaddr_width_p`, 39: virtual address width.
- `instr_width_p`, 32: instruction width.
- `br_metadata_width_p`, 64: branch metadata forward width; matches `branch_metadata_fwd_width_p`.
- `els_p`, 4: FIFO depth; power of two, ≥2.
- `clk_i` in 1: the single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `flush_i` in 1: redirect; discard all entries.
- `v_i` in 1: fetch entry valid.
- `ready_o` out 1: buffer can accept; ready-and handshake.
- `pc_i` in `vaddr_width_p`: fetch PC.
- `instr_i` in `instr_width_p`: fetched instruction.
- `br_metadata_fwd_i` in `br_metadata_width_p`: branch metadata.
- `exc_i` in 2: 0 = fetch, 1 = itlb miss, 2 = instr page fault, 3 = instr access fault.
- `v_o` out 1: head entry valid.
- `yumi_i` in 1: consumer takes head; legal only when `v_o`.
- `pc_o` out `vaddr_width_p`: head PC.
- `instr_o` out `instr_width_p`: head instruction.
- `br_metadata_fwd_o` out `br_metadata_width_p`: head metadata.
- `exc_o` out 2: head entry code.
- `count_o` out `$clog2(els_p+1)`: occupancy.

## Operation
- Storage: `els_p` entries of {pc, instr, metadata, exc}.
- Read and write pointers are `$clog2(els_p)` bits and wrap from `els_p-1` to 0.
- Occupancy counter ranges 0..`els_p`.
- State machine:
  - `e_run` → `e_stall` on an accepted enqueue with `exc_i != 0`.
  - `e_stall` → `e_run` only on `flush_i`.
  - Reset state is `e_run`.
- `ready_o = (state == e_run) & (count != els_p) & ~flush_i`.
- Enqueue occurs when `v_i & ready_o`: write entry at the write pointer, then increment the write pointer.
- Exception entries store `instr` as 0. PC and metadata are stored unchanged.
- Dequeue occurs when `yumi_i & ~flush_i`: increment the read pointer.
- Counter update is +1 on enqueue only, -1 on dequeue only, and unchanged on both.
- `v_o = (count != 0)`.
- Data outputs are driven from the read-pointer entry when `v_o`, and forced to 0 when `v_o = 0`.
- `flush_i` has priority over everything:
  - Pointers and count reset to 0; state goes to `e_run`.
  - Same-cycle `v_i` is ignored, because `ready_o` is low.
  - Same-cycle `yumi_i` is ignored.
- Entries already in the buffer when `e_stall` is entered remain dequeueable. Only new enqueues are blocked.
- `yumi_i` while `v_o = 0` is illegal. The design ignores it with no pointer change, and the bench asserts it never occurs.
- No bypass: an entry accepted while the buffer is empty is not visible at the output in the same cycle.

## Timing
- Reset (asynchronous, immediate) drives:
  - `v_o = 0`, `count_o = 0`, all data outputs 0.
  - `ready_o = 1`, once `reset_i` deasserts and `flush_i` is low.
  - State `e_run`, pointers 0.
- Enqueue-to-`v_o` latency is 1 cycle: accepted at edge N, visible after edge N.
- Dequeue takes effect at the clock edge where `yumi_i` is sampled high. The next entry, or `v_o = 0`, is presented after that edge.
- When full, `ready_o = 0` that cycle even if `yumi_i` is high: no full-throughput pass-through. `ready_o` rises the cycle after the dequeue.
- When one entry remains and both enqueue and dequeue occur, count stays 1 and `v_o` stays high with the new head.
- Flush takes effect at the edge where it is sampled: `v_o = 0` and `count_o = 0` the following cycle, and `ready_o` is low during the flush cycle itself.
- Asserting reset mid-stream discards all entries asynchronously.
- All outputs are registered-state derived. Only `ready_o` has a combinational path, from `flush_i`.

## Test plan
- **Fill:** with `els_p = 4`, enqueue PCs 0x1000, 0x1004, 0x1008, 0x100C with no yumi → `count_o = 4`, `ready_o = 0`. Then dequeue 4 times → `pc_o` sequence is 0x1000..0x100C, and `count_o` ends at 0 with `v_o = 0`.
- **Wrap-around:** stream 10 entries with `yumi_i` held high whenever `v_o` → strict in-order output and `count_o ≤ 1`, which exercises pointer wrap.
- **Exception stall:** enqueue PC 0x2000 fetch, then PC 0x2004 with `exc_i = 2` → `ready_o = 0` from the next cycle. `v_i` with 0x2008 is not accepted. Dequeue yields 0x2000 (exc 0), then 0x2004 (exc 2, instr 0). Then assert `flush_i` → `ready_o = 1` the next cycle.
- **Flush with traffic:** 3 entries held, then same cycle `flush_i = v_i = yumi_i = 1` → next cycle `count_o = 0`, `v_o = 0`, and the new entry is dropped.
- **Simultaneous enqueue/dequeue at count 1:** `count_o` stays 1 and `pc_o` advances to the new entry.
- **Async reset mid-stream:** 2 entries present, pulse `reset_i` between clock edges → `v_o = 0` and `count_o = 0` immediately, before the next edge.

Source files
------------

// File: rtl/bp_fe_fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_fe_fetch_buffer                                                       |
// | In-order FIFO between IF2 and the FE queue; blocks on fetch exception.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bp_fe_fetch_buffer #(
    parameter int vaddr_width_p       = 39,
    parameter int instr_width_p       = 32,
    parameter int br_metadata_width_p = 64,
    parameter int els_p               = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic [vaddr_width_p-1:0]       pc_i,
    input  logic [instr_width_p-1:0]       instr_i,
    input  logic [br_metadata_width_p-1:0] br_metadata_fwd_i,
    input  logic [1:0]                     exc_i,
    output logic                           v_o,
    input  logic                           yumi_i,
    output logic [vaddr_width_p-1:0]       pc_o,
    output logic [instr_width_p-1:0]       instr_o,
    output logic [br_metadata_width_p-1:0] br_metadata_fwd_o,
    output logic [1:0]                     exc_o,
    output logic [$clog2(els_p+1)-1:0]     count_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p+1);
    localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

    typedef enum logic [0:0] {
        e_run   = 1'b0,
        e_stall = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ptr_w_lp-1:0]   rptr_q, rptr_d;
    logic [ptr_w_lp-1:0]   wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]   count_q, count_d;

    logic [vaddr_width_p-1:0]       pc_mem    [els_p];
    logic [instr_width_p-1:0]       instr_mem [els_p];
    logic [br_metadata_width_p-1:0] md_mem    [els_p];
    logic [1:0]                     exc_mem   [els_p];

    logic enq, deq;

    assign ready_o = (state_q == e_run) & (count_q != full_lp) & ~flush_i;
    assign enq     = v_i & ready_o;
    // Dequeue on an empty buffer is illegal; gate it so pointers stay put.
    assign deq     = yumi_i & ~flush_i & (count_q != '0);

    always_comb begin
        state_d = state_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            state_d = e_run;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                wptr_d = wptr_q + ptr_w_lp'(1);
                if (exc_i != 2'd0) begin
                    state_d = e_stall;
                end
            end
            if (deq) begin
                rptr_d = rptr_q + ptr_w_lp'(1);
            end
            if (enq & ~deq) begin
                count_d = count_q + cnt_w_lp'(1);
            end else if (deq & ~enq) begin
                count_d = count_q - cnt_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_run;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            pc_mem[wptr_q]    <= pc_i;
            instr_mem[wptr_q] <= (exc_i != 2'd0) ? '0 : instr_i;
            md_mem[wptr_q]    <= br_metadata_fwd_i;
            exc_mem[wptr_q]   <= exc_i;
        end
    end

    assign v_o               = (count_q != '0);
    assign count_o           = count_q;
    assign pc_o              = v_o ? pc_mem[rptr_q]    : '0;
    assign instr_o           = v_o ? instr_mem[rptr_q] : '0;
    assign br_metadata_fwd_o = v_o ? md_mem[rptr_q]    : '0;
    assign exc_o             = v_o ? exc_mem[rptr_q]   : '0;

endmodule
`default_nettype wire
